serial_adder: RTL and testbench
===============================

# serial_adder

Parametrised multi-cycle adder that sums two WIDTH-bit operands plus carry-in, DIGIT bits per clock, using a start/busy/done protocol. It is the sequential, width-generic successor to the single-bit full adder and sits in the datapath wherever area matters more than latency. The operands are captured on start. Results are held stable until the next accepted start.

## Interface
Parameters:
- WIDTH, 8, operand and sum width in bits; must be ≥1.
- DIGIT, 1, bits added per cycle; must be ≥1, and WIDTH % DIGIT must equal 0 (elaboration-time assertion).

Ports:
- clk_in, input, 1, single clock; all state updates on the rising edge.
- rst_in, input, 1, asynchronous, active-high reset.
- start_in, input, 1, request to start an addition; sampled only in IDLE.
- a_in, input, WIDTH, operand A; sampled with an accepted start.
- b_in, input, WIDTH, operand B; sampled with an accepted start.
- c_in, input, 1, carry-in; sampled with an accepted start.
- busy_out, output, 1, high while an addition is in progress.
- done_out, output, 1, one-cycle pulse when sum_out/c_out update.
- sum_out, output, WIDTH, registered result, i.e. (a_in + b_in + c_in) mod 2^WIDTH.
- c_out, output, 1, registered carry-out of the full WIDTH-bit sum.

## Operation
- States: IDLE, BUSY. N = WIDTH/DIGIT digits; the digit counter is $clog2(N)+1 bits wide.
- IDLE with start_in=1 at an edge:
  - latch a_in and b_in into shift registers;
  - set carry register to c_in and counter to 0;
  - go to BUSY.
- IDLE with start_in=0: hold all state.
- BUSY, each edge:
  - add the low DIGIT bits of A and B plus the carry;
  - shift the DIGIT-bit result into the top of the sum accumulator, LSB digit first;
  - shift A and B right by DIGIT;
  - update the carry and increment the counter.
- BUSY, edge processing digit N-1:
  - load sum_out with the final accumulator value and c_out with the final carry;
  - pulse done_out;
  - go to IDLE.
- start_in in BUSY is ignored; no queuing, no error flag.
- sum_out and c_out hold the previous result throughout BUSY. They change only on the done edge.
- Arithmetic is unsigned. Overflow appears only as c_out=1. There is no saturation.
- Reset (any time, including mid-operation):
  - go to IDLE;
  - busy_out=0, done_out=0, sum_out=0, c_out=0;
  - clear internal registers;
  - the aborted operation produces no done_out.

## Timing
- Start accepted at edge T0 → busy_out=1 from after T0 through the edge T0+N.
- done_out=1 for exactly the cycle after edge T0+N; sum_out/c_out are valid from the same point.
- Latency: N cycles from start edge to result. Throughput: one addition per N cycles.
- busy_out and done_out are never high simultaneously. Both are registered.
- Back-to-back operation:
  - start_in may be high in the cycle where done_out=1, because the block is already in IDLE.
  - That start is accepted, so busy_out rises again directly after the done pulse.
- DIGIT=WIDTH (N=1): the result is ready one edge after start. The done pulse follows immediately.
- Reset deassertion: the first edge with rst_in=0 may accept start.

## Structure
- Shared package serial_adder_pkg:
  - state_t enum {IDLE, BUSY};
  - function for N and the counter-width computation.
- Sub-module digit_adder, parameter DIGIT:
  - combinational DIGIT-bit ripple adder built from full-adder cells;
  - inputs a, b, cin; outputs s[DIGIT], cout.
- Top module: FSM, counter, operand/sum shift registers, output registers.

## Test plan
- WIDTH=8, DIGIT=1:
  - stimulus: a=0xFF, b=0x01, c=0, one-cycle start;
  - required: busy_out high 8 cycles, then done_out pulse, sum_out=0x00, c_out=1.
- WIDTH=8, DIGIT=4:
  - stimulus: a=0x5A, b=0x3C, c=1;
  - required: done_out 2 cycles after start, sum_out=0x97, c_out=0.
- Start ignored in BUSY:
  - stimulus: a=0x10, b=0x20, c=0; pulse start_in again with a=0xFF, b=0xFF mid-operation;
  - required: result is 0x30, c_out=0, exactly one done_out.
- Reset mid-operation:
  - stimulus: assert rst_in at cycle 3 of 8;
  - required: outputs are zero immediately (asynchronous) and no done_out follows.
  - stimulus: then start with a=0x01, b=0x01;
  - required: sum_out=0x02.
- Back-to-back:
  - stimulus: start asserted during the done cycle, with a=0x80, b=0x80;
  - required: busy_out rises on the next cycle; second result is sum_out=0x00, c_out=1; the first result holds until then.
- Exhaustive:
  - configurations: WIDTH=4 with DIGIT=1, 2 and 4;
  - stimulus: all 512 (a, b, c) combinations;
  - required: results match the behavioural model a+b+c.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//
// Shared definitions for the serial adder slice.
//   state_t       : controller states (IDLE waits for start, BUSY adds digits)
//   num_digits()  : number of DIGIT-bit digits in a WIDTH-bit operand
//   count_width() : width of the digit counter for a given digit count
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Guarded against DIGIT=0 so that an illegal parameter set still
  // elaborates far enough to reach the parameter check in the top.
  function automatic int num_digits(input int width, input int digit);
    return (digit > 0) ? (width / digit) : 1;
  endfunction

  // One extra bit beyond $clog2 keeps the counter wide enough when N is
  // a power of two (and gives N=1 a 1-bit counter rather than a 0-bit one).
  function automatic int count_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage : serial_adder_pkg

// File: rtl/serial_adder_digit_adder.sv
// -----------------------------------------------------------------------------
// digit_adder
//
// Combinational DIGIT-bit ripple-carry adder built from full-adder cells.
//   a, b  : DIGIT-bit addends
//   cin   : carry into bit 0
//   s     : DIGIT-bit sum
//   cout  : carry out of the top bit
// -----------------------------------------------------------------------------
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);

  // c[i] is the carry into bit i; c[DIGIT] leaves the digit.
  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[DIGIT];

endmodule : digit_adder

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Multi-cycle unsigned adder: computes a_in + b_in + c_in over WIDTH bits,
// DIGIT bits per clock, least-significant digit first. Operands are captured
// on an accepted start; the result registers hold their value until the
// edge that completes the next addition.
//
// Parameters
//   WIDTH : operand / sum width (>= 1)
//   DIGIT : bits added per clock (>= 1, must divide WIDTH)
//
// Ports
//   clk_in   : clock, rising edge
//   rst_in   : asynchronous active-high reset
//   start_in : start request, only looked at while idle
//   a_in     : operand A, captured with an accepted start
//   b_in     : operand B, captured with an accepted start
//   c_in     : carry-in, captured with an accepted start
//   busy_out : high while an addition is in progress
//   done_out : one-cycle pulse when sum_out / c_out update
//   sum_out  : registered (a + b + c) mod 2^WIDTH
//   c_out    : registered carry-out of the full-width sum
//
// Timing: start accepted at edge T0 -> busy_out high after T0 up to edge
// T0+N, done_out high for the single cycle after edge T0+N (N = WIDTH/DIGIT).
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out
);

  localparam int N  = num_digits(WIDTH, DIGIT);
  localparam int CW = count_width(N);

  // Reject parameter sets the digit slicing cannot handle.
  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_adder: WIDTH=%0d must be >= 1 and a multiple of DIGIT=%0d",
           WIDTH, DIGIT);
  end

  state_t          state;
  logic [WIDTH-1:0] a_sr;     // operand A, consumed from the bottom
  logic [WIDTH-1:0] b_sr;     // operand B, consumed from the bottom
  logic [WIDTH-1:0] acc;      // partial sum, filled from the top
  logic             carry;    // carry between digits
  logic [CW-1:0]    cnt;      // index of the digit being added

  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic [WIDTH-1:0] acc_next;
  logic             last_digit;

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit_adder (
    .a    (a_sr[DIGIT-1:0]),
    .b    (b_sr[DIGIT-1:0]),
    .cin  (carry),
    .s    (dig_sum),
    .cout (dig_cout)
  );

  // New digits enter at the top of the accumulator; after N shifts the
  // first digit has reached bit 0 and acc_next holds the complete sum.
  // NOTE: every always_comb output gets a full default before any partial
  // overwrite, so no path leaves a bit unassigned and no latch is inferred.
  always_comb begin
    acc_next                    = acc >> DIGIT;
    acc_next[WIDTH-1 -: DIGIT]  = dig_sum;
  end

  assign last_digit = (cnt == CW'(N - 1));

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: there are no memories here; every register, including the shift
  // registers, is cleared by the asynchronous reset so an aborted addition
  // leaves nothing behind.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      busy_out <= 1'b0;
      done_out <= 1'b0;
      sum_out  <= '0;
      c_out    <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            a_sr     <= a_in;
            b_sr     <= b_in;
            carry    <= c_in;
            acc      <= '0;
            cnt      <= '0;
            busy_out <= 1'b1;
            state    <= BUSY;
          end
        end

        BUSY: begin
          a_sr  <= a_sr >> DIGIT;
          b_sr  <= b_sr >> DIGIT;
          acc   <= acc_next;
          carry <= dig_cout;
          cnt   <= cnt + CW'(1);
          if (last_digit) begin
            sum_out  <= acc_next;
            c_out    <= dig_cout;
            done_out <= 1'b1;
            busy_out <= 1'b0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Directed bench for serial_adder. Two 8-bit instances (DIGIT=1 and DIGIT=4)
// cover protocol timing, ignored starts, reset abort and back-to-back use;
// three 4-bit instances (DIGIT=1, 2, 4) are swept over every a, b, c.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] a8, b8;
  logic       c8;
  logic       start1, start4;

  logic       busy1, done1, cout1;
  logic [7:0] sum1;
  logic       busy4, done4, cout4;
  logic [7:0] sum4;

  logic [3:0] a_w, b_w;
  logic       c_w, start_w;
  logic [2:0] busy_w, done_w, cout_w;
  logic [3:0] sum_w [3];

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut8_d1 (
    .clk_in(clk), .rst_in(rst), .start_in(start1), .a_in(a8), .b_in(b8), .c_in(c8),
    .busy_out(busy1), .done_out(done1), .sum_out(sum1), .c_out(cout1));

  serial_adder #(.WIDTH(8), .DIGIT(4)) dut8_d4 (
    .clk_in(clk), .rst_in(rst), .start_in(start4), .a_in(a8), .b_in(b8), .c_in(c8),
    .busy_out(busy4), .done_out(done4), .sum_out(sum4), .c_out(cout4));

  serial_adder #(.WIDTH(4), .DIGIT(1)) dut4_d1 (
    .clk_in(clk), .rst_in(rst), .start_in(start_w), .a_in(a_w), .b_in(b_w), .c_in(c_w),
    .busy_out(busy_w[0]), .done_out(done_w[0]), .sum_out(sum_w[0]), .c_out(cout_w[0]));

  serial_adder #(.WIDTH(4), .DIGIT(2)) dut4_d2 (
    .clk_in(clk), .rst_in(rst), .start_in(start_w), .a_in(a_w), .b_in(b_w), .c_in(c_w),
    .busy_out(busy_w[1]), .done_out(done_w[1]), .sum_out(sum_w[1]), .c_out(cout_w[1]));

  serial_adder #(.WIDTH(4), .DIGIT(4)) dut4_d4 (
    .clk_in(clk), .rst_in(rst), .start_in(start_w), .a_in(a_w), .b_in(b_w), .c_in(c_w),
    .busy_out(busy_w[2]), .done_out(done_w[2]), .sum_out(sum_w[2]), .c_out(cout_w[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int ndone;
    int got [3];

    rst     = 1'b1;
    a8      = '0;
    b8      = '0;
    c8      = 1'b0;
    start1  = 1'b0;
    start4  = 1'b0;
    a_w     = '0;
    b_w     = '0;
    c_w     = 1'b0;
    start_w = 1'b0;

    // ---- reset state ----
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", busy1, 1'b0);
    check("rst_done", done1, 1'b0);
    check("rst_sum",  sum1,  8'h00);
    check("rst_cout", cout1, 1'b0);
    check("rst_sum4", sum4,  8'h00);
    rst = 1'b0;

    // ---- WIDTH=8 DIGIT=1: 0xFF + 0x01 + 0 -> 0x00 carry 1 ----
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("d1_busy_%0d", i), busy1, 1'b1);
      check($sformatf("d1_nodone_%0d", i), done1, 1'b0);
      check($sformatf("d1_hold_%0d", i), sum1, 8'h00);
      @(negedge clk);
    end
    check("d1_done",      done1, 1'b1);
    check("d1_busy_low",  busy1, 1'b0);
    check("d1_sum",       sum1,  8'h00);
    check("d1_cout",      cout1, 1'b1);
    @(negedge clk);
    check("d1_done_pulse", done1, 1'b0);
    check("d1_sum_held",   sum1,  8'h00);
    check("d1_cout_held",  cout1, 1'b1);

    // ---- WIDTH=8 DIGIT=4: 0x5A + 0x3C + 1 -> 0x97 carry 0 ----
    a8 = 8'h5A; b8 = 8'h3C; c8 = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check("d4_busy_0", busy4, 1'b1);
    check("d4_done_0", done4, 1'b0);
    @(negedge clk);
    check("d4_busy_1", busy4, 1'b1);
    check("d4_done_1", done4, 1'b0);
    @(negedge clk);
    check("d4_done", done4, 1'b1);
    check("d4_busy_low", busy4, 1'b0);
    check("d4_sum",  sum4,  8'h97);
    check("d4_cout", cout4, 1'b0);

    // ---- start while busy is ignored: 0x10 + 0x20 -> 0x30 ----
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; c8 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    ndone = 0;
    for (int i = 0; i < 16; i++) begin
      if (done1) begin
        ndone++;
        check("ign_sum",  sum1,  8'h30);
        check("ign_cout", cout1, 1'b0);
      end
      @(negedge clk);
    end
    check("ign_done_count", ndone, 1);
    check("ign_idle",       busy1, 1'b0);
    check("ign_sum_final",  sum1,  8'h30);

    // ---- reset mid-operation, then 0x01 + 0x01 -> 0x02 ----
    a8 = 8'h55; b8 = 8'h0F; c8 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy1, 1'b0);
    check("arst_done", done1, 1'b0);
    check("arst_sum",  sum1,  8'h00);
    check("arst_cout", cout1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done1) ndone++;
    end
    check("arst_no_done", ndone, 0);
    check("arst_idle",    busy1, 1'b0);
    a8 = 8'h01; b8 = 8'h01; c8 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 12 && !done1; i++) @(negedge clk);
    check("post_rst_done", done1, 1'b1);
    check("post_rst_sum",  sum1,  8'h02);
    check("post_rst_cout", cout1, 1'b0);

    // ---- back-to-back: 0x01+0x02 -> 0x03, then 0x80+0x80 -> 0x00 carry 1 ----
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h02; c8 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 12 && !done1; i++) @(negedge clk);
    check("b2b_first_done", done1, 1'b1);
    check("b2b_first_sum",  sum1,  8'h03);
    a8 = 8'h80; b8 = 8'h80; c8 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("b2b_busy_rise", busy1, 1'b1);
    check("b2b_no_done",   done1, 1'b0);
    check("b2b_hold_0",    sum1,  8'h03);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("b2b_hold_%0d", i), {cout1, sum1}, 9'h003);
    end
    @(negedge clk);
    check("b2b_second_done", done1, 1'b1);
    check("b2b_second_sum",  sum1,  8'h00);
    check("b2b_second_cout", cout1, 1'b1);

    // ---- exhaustive WIDTH=4, DIGIT=1/2/4 ----
    @(negedge clk);
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          a_w = 4'(ia); b_w = 4'(ib); c_w = ic[0]; start_w = 1'b1;
          @(negedge clk);
          start_w = 1'b0;
          got = '{0, 0, 0};
          for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
              if (done_w[d]) begin
                got[d]++;
                check($sformatf("exh_dut%0d_%h_%h_%0d", d, ia, ib, ic),
                      {cout_w[d], sum_w[d]}, ia + ib + ic);
              end
            end
          end
          for (int d = 0; d < 3; d++)
            check($sformatf("exh_dut%0d_ndone_%h_%h_%0d", d, ia, ib, ic), got[d], 1);
          check($sformatf("exh_idle_%h_%h_%0d", ia, ib, ic), busy_w, 3'b000);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_adder
